// File: rtl/axi_wr_dos_guard.sv
// AXI4 write-path guard: polices AW/W/B from one untrusted master, closes
// offending bursts cleanly, answers SLVERR upstream and locks the master out.
module axi_wr_dos_guard #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 4,
    parameter int MAX_LEN      = 15,
    parameter int W_TIMEOUT    = 256,
    parameter int TOKEN_MAX    = 4,
    parameter int TOKEN_PERIOD = 64,
    parameter int LOCK_CYCLES  = 1024
) (
    input  logic                clock,
    input  logic                reset,
    // upstream (untrusted master)
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic [ID_W-1:0]     s_awid,
    input  logic                s_wvalid,
    output logic                s_wready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    output logic                s_bvalid,
    input  logic                s_bready,
    output logic [1:0]          s_bresp,
    output logic [ID_W-1:0]     s_bid,
    // downstream (interconnect slave port)
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic [ID_W-1:0]     m_awid,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    input  logic [ID_W-1:0]     m_bid,
    // monitoring
    output logic                lock_active,
    output logic                dos_alarm,
    output logic [1:0]          viol_cause,
    output logic [15:0]         viol_count
);

    localparam int WD_W = $clog2(W_TIMEOUT + 1);
    localparam int TK_W = $clog2(TOKEN_MAX + 1);
    localparam int RF_W = $clog2(TOKEN_PERIOD + 1);
    localparam int LK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(W_TIMEOUT);
    localparam logic [TK_W-1:0] TK_FULL   = TK_W'(TOKEN_MAX);
    localparam logic [RF_W-1:0] RF_LAST   = RF_W'(TOKEN_PERIOD - 1);
    localparam logic [LK_W-1:0] LK_LAST   = LK_W'(LOCK_CYCLES - 1);
    localparam logic [7:0]      MAX_LEN_V = 8'(MAX_LEN);
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [3:0] {
        IDLE, AW_FWD, DATA, FLUSH, FLUSH_RESP, RESP, DRAIN, ERR_RESP, LOCKOUT
    } state_t;

    function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
        return (v >= WD_LIMIT) ? WD_LIMIT : v + WD_W'(1);
    endfunction

    function automatic logic [15:0] cnt_sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic [TK_W-1:0]   tokens_q, tokens_d;
    logic [RF_W-1:0]   refill_cnt_q, refill_cnt_d;
    logic [LK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic              mismatch_q, mismatch_d;
    logic [1:0]        viol_cause_q, viol_cause_d;
    logic [15:0]       viol_count_q, viol_count_d;
    logic              dos_alarm_q, dos_alarm_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [ID_W-1:0]   id_q, id_d;

    logic              aw_load;
    logic              consume;
    logic              refill;
    logic              gen_last;
    logic [WD_W-1:0]   wdog_inc;
    logic              wd_expire;

    assign gen_last  = (beat_cnt_q == len_q);
    assign wdog_inc  = wd_sat_inc(wdog_q);
    assign wd_expire = (wdog_inc == WD_LIMIT);
    assign refill    = (refill_cnt_q == RF_LAST);

    assign m_awaddr    = addr_q;
    assign m_awlen     = len_q;
    assign m_awsize    = size_q;
    assign m_awburst   = burst_q;
    assign m_awid      = id_q;
    assign lock_active = (state_q == LOCKOUT);
    assign dos_alarm   = dos_alarm_q;
    assign viol_cause  = viol_cause_q;
    assign viol_count  = viol_count_q;

    always_comb begin
        state_d      = state_q;
        wdog_d       = '0;
        beat_cnt_d   = beat_cnt_q;
        lock_cnt_d   = '0;
        mismatch_d   = mismatch_q;
        viol_cause_d = viol_cause_q;
        dos_alarm_d  = 1'b0;
        aw_load      = 1'b0;
        consume      = 1'b0;

        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = 2'b00;
        s_bid     = id_q;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_wdata   = s_wdata;
        m_wstrb   = s_wstrb;
        m_wlast   = gen_last;
        m_bready  = 1'b0;

        case (state_q)
            IDLE: begin
                s_awready = (tokens_q != '0) && !reset;
                if (s_awvalid && (tokens_q != '0)) begin
                    aw_load    = 1'b1;
                    consume    = 1'b1;
                    beat_cnt_d = '0;
                    mismatch_d = 1'b0;
                    if (s_awlen <= MAX_LEN_V) begin
                        state_d = AW_FWD;
                    end else begin
                        state_d      = DRAIN;
                        dos_alarm_d  = 1'b1;
                        viol_cause_d = 2'd1;
                    end
                end
            end
            AW_FWD: begin
                m_awvalid = 1'b1;
                if (m_awready) state_d = DATA;
            end
            DATA: begin
                m_wvalid = s_wvalid;
                s_wready = m_wready;
                wdog_d   = wdog_q;
                if (s_wvalid && m_wready) begin
                    wdog_d     = '0;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (s_wlast != gen_last) mismatch_d = 1'b1;
                    if (gen_last) state_d = RESP;
                end else if (!s_wvalid) begin
                    // only an idle master counts; a stalled interconnect does not
                    wdog_d = wdog_inc;
                    if (wd_expire) begin
                        state_d      = FLUSH;
                        dos_alarm_d  = 1'b1;
                        viol_cause_d = 2'd2;
                    end
                end
            end
            FLUSH: begin
                m_wvalid = 1'b1;
                m_wdata  = '0;
                m_wstrb  = '0;
                if (m_wready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (gen_last) state_d = FLUSH_RESP;
                end
            end
            FLUSH_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_d = ERR_RESP;
            end
            RESP: begin
                s_bvalid = m_bvalid;
                m_bready = s_bready;
                s_bid    = m_bid;
                s_bresp  = mismatch_q ? RESP_SLVERR : m_bresp;
                if (m_bvalid && s_bready) begin
                    if (mismatch_q) begin
                        state_d      = LOCKOUT;
                        dos_alarm_d  = 1'b1;
                        viol_cause_d = 2'd3;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                s_wready = 1'b1;
                if (s_wvalid) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (gen_last) state_d = ERR_RESP;
                end else begin
                    wdog_d = wdog_inc;
                    if (wd_expire) state_d = ERR_RESP;
                end
            end
            ERR_RESP: begin
                s_bvalid = 1'b1;
                s_bresp  = RESP_SLVERR;
                s_bid    = id_q;
                if (s_bready) begin
                    state_d = LOCKOUT;
                end else begin
                    wdog_d = wdog_inc;
                    if (wd_expire) state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                lock_cnt_d = lock_cnt_q + LK_W'(1);
                if (lock_cnt_q == LK_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // each watched state starts its idle count from zero
        if (state_d != state_q) wdog_d = '0;

        viol_count_d = dos_alarm_d ? cnt_sat_inc(viol_count_q) : viol_count_q;

        refill_cnt_d = refill ? '0 : refill_cnt_q + RF_W'(1);
        tokens_d     = tokens_q;
        if (refill && !consume) begin
            if (tokens_q != TK_FULL) tokens_d = tokens_q + TK_W'(1);
        end else if (consume && !refill) begin
            tokens_d = tokens_q - TK_W'(1);
        end

        addr_d  = aw_load ? s_awaddr  : addr_q;
        len_d   = aw_load ? s_awlen   : len_q;
        size_d  = aw_load ? s_awsize  : size_q;
        burst_d = aw_load ? s_awburst : burst_q;
        id_d    = aw_load ? s_awid    : id_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wdog_q       <= '0;
            beat_cnt_q   <= '0;
            tokens_q     <= TK_FULL;
            refill_cnt_q <= '0;
            lock_cnt_q   <= '0;
            mismatch_q   <= 1'b0;
            viol_cause_q <= 2'd0;
            viol_count_q <= '0;
            dos_alarm_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            beat_cnt_q   <= beat_cnt_d;
            tokens_q     <= tokens_d;
            refill_cnt_q <= refill_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            mismatch_q   <= mismatch_d;
            viol_cause_q <= viol_cause_d;
            viol_count_q <= viol_count_d;
            dos_alarm_q  <= dos_alarm_d;
        end
    end

    // latched AW fields are pure data and are only meaningful after a load
    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        len_q   <= len_d;
        size_q  <= size_d;
        burst_q <= burst_d;
        id_q    <= id_d;
    end

endmodule
